// File: rtl/cheb_pkg.sv
// cheb_pkg: shared widths, coefficients and response entry type
// for the Chebyshev evaluator request scheduler.
package cheb_pkg;

    localparam int DW           = 18;
    localparam int IDW          = 3;
    localparam int PIPE_LAT_DEF = 12;

    localparam logic [DW-1:0] COEF0 = 18'h00082;
    localparam logic [DW-1:0] COEF1 = 18'h01CC8;
    localparam logic [DW-1:0] COEF2 = 18'h3DF43;
    localparam logic [DW-1:0] COEF3 = 18'h01EC5;
    localparam logic [DW-1:0] COEF4 = 18'h3F4AB;

    typedef struct packed {
        logic [DW-1:0]  y;
        logic [IDW-1:0] id;
    } rsp_entry_t;

endpackage

// File: rtl/cheb_rsp_fifo.sv
// cheb_rsp_fifo: first-word-fall-through circular buffer of
// response entries with an occupancy count.
module cheb_rsp_fifo
    import cheb_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  rsp_entry_t    wdata,
    input  logic          pop,
    output rsp_entry_t    rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    rsp_entry_t    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;

    // storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wdata;
        end
    end

    // wrapping pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            end
            if (pop) begin
                rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rp];
    assign empty = (count == '0);

endmodule

// File: rtl/cheb_eval_sched.sv
// cheb_eval_sched: round-robin issue onto the fixed-latency
// Chebyshev datapath with tag tracking and in-order return.
module cheb_eval_sched
    import cheb_pkg::*;
#(
    parameter  int N_REQ      = 4,
    parameter  int PIPE_LAT   = PIPE_LAT_DEF,
    parameter  int FIFO_DEPTH = 16,
    localparam int IW         = $clog2(N_REQ),
    localparam int FW         = $clog2(PIPE_LAT + FIFO_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                async,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_x,
    output logic [N_REQ-1:0]    req_ready,
    output logic [DW-1:0]       dp_xin,
    input  logic [DW-1:0]       dp_yout,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DW-1:0]       rsp_y,
    output logic [IW-1:0]       rsp_id,
    output logic [FW-1:0]       inflight
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [DW-1:0]   xs [N_REQ];
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   nxt;
    logic [IW-1:0]   gnt;
    logic            gnt_vld;
    logic            can_issue;
    logic            issue;
    logic            pop;
    logic            empty;
    logic [PIPE_LAT:0] tag_v;
    logic [IW-1:0]   tag_id [PIPE_LAT+1];
    logic [CW-1:0]   fcount;
    rsp_entry_t      wr_e;
    rsp_entry_t      head;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign xs[i] = req_x[i*DW +: DW];
    end

    // first valid requester searching cyclically after ptr
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        nxt     = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            nxt = IW'((int'(ptr) + k) % N_REQ);
            if (req_valid[nxt]) begin
                gnt_vld = 1'b1;
                gnt     = nxt;
            end
        end
    end

    // credit covers every sample that will land in the FIFO
    assign inflight  = FW'($countones(tag_v)) + FW'(fcount);
    assign can_issue = (inflight < FW'(FIFO_DEPTH));
    assign issue     = can_issue & gnt_vld;
    assign req_ready = issue ? (N_REQ'(1) << gnt) : '0;

    // issue register, latency-matched tag pipe, RR pointer
    always_ff @(posedge clk) begin
        if (async) begin
            ptr    <= IW'(N_REQ - 1);
            dp_xin <= '0;
            tag_v  <= '0;
            for (int s = 0; s <= PIPE_LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            dp_xin    <= issue ? xs[gnt] : '0;
            tag_v     <= {tag_v[PIPE_LAT-1:0], issue};
            tag_id[0] <= issue ? gnt : '0;
            for (int s = 1; s <= PIPE_LAT; s++) begin
                tag_id[s] <= tag_id[s-1];
            end
            if (issue) begin
                ptr <= gnt;
            end
        end
    end

    // result paired with the tag that aligns with it
    always_comb begin
        wr_e    = '0;
        wr_e.y  = dp_yout;
        wr_e.id = IDW'(tag_id[PIPE_LAT]);
    end

    cheb_rsp_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (async),
        .push  (tag_v[PIPE_LAT]),
        .wdata (wr_e),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (fcount)
    );

    assign rsp_valid = !empty;
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_y     = empty ? '0 : head.y;
    assign rsp_id    = empty ? '0 : IW'(head.id);

endmodule

// File: tb/tb_cheb_eval_sched.sv
// tb_cheb_eval_sched: random and directed traffic against an
// issue-order queue model plus a Horner datapath stand-in.
`timescale 1ns/1ps
module tb_cheb_eval_sched;
    import cheb_pkg::*;

    localparam int N  = 4;
    localparam int PL = 12;
    localparam int FD = 16;
    localparam int IW = 2;
    localparam int FW = $clog2(PL + FD + 1);

    logic            clk = 1'b0;
    logic            async = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_x = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   dp_xin;
    logic [DW-1:0]   dp_yout;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_y;
    logic [IW-1:0]   rsp_id;
    logic [FW-1:0]   inflight;
    logic [DW-1:0]   dpipe [PL];

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            id;
        logic [DW-1:0] x;
        int            due;
    } txn_t;

    txn_t          q[$];
    int            cyc = 0;
    int            mptr = N - 1;
    logic          armed = 1'b0;
    logic [N-1:0]  hs_now = '0;
    logic [DW-1:0] exp_dpx = '0;
    int            n_iss = 0;
    int            n_rsp = 0;

    always #5 clk = ~clk;

    cheb_eval_sched #(
        .N_REQ      (N),
        .PIPE_LAT   (PL),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk       (clk),
        .async     (async),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_ready (req_ready),
        .dp_xin    (dp_xin),
        .dp_yout   (dp_yout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .inflight  (inflight)
    );

    function automatic logic [DW-1:0] horner(input logic [DW-1:0] x);
        logic [DW-1:0] c [5];
        longint a;
        longint xv;
        longint p;
        c[0] = COEF0;
        c[1] = COEF1;
        c[2] = COEF2;
        c[3] = COEF3;
        c[4] = COEF4;
        xv = longint'($signed(x));
        a  = longint'($signed(c[4]));
        for (int k = 3; k >= 0; k--) begin
            p = a * xv;
            a = (p >>> 12) + longint'($signed(c[k]));
            a = longint'($signed(a[DW-1:0]));
        end
        return a[DW-1:0];
    endfunction

    // datapath stand-in: PL-cycle Horner pipe
    assign dp_yout = dpipe[PL-1];
    always @(posedge clk) begin
        if (async) begin
            for (int k = 0; k < PL; k++) dpipe[k] <= '0;
        end else begin
            dpipe[0] <= horner(dp_xin);
            for (int k = 1; k < PL; k++) dpipe[k] <= dpipe[k-1];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the issue-order model
    always @(negedge clk) begin : cmp
        logic [N-1:0] er;
        logic         ev;
        logic         found;
        int           j;
        int           fn;
        txn_t         t;
        cyc++;
        if (async) begin
            q.delete();
            mptr    = N - 1;
            hs_now  = '0;
            exp_dpx = '0;
            n_iss   = 0;
            n_rsp   = 0;
            armed   = 1'b1;
        end else if (armed) begin
            er    = '0;
            found = 1'b0;
            if (q.size() < FD) begin
                for (int k = 1; k <= N; k++) begin
                    j = (mptr + k) % N;
                    if (!found && req_valid[j]) begin
                        er[j] = 1'b1;
                        found = 1'b1;
                    end
                end
            end
            chk("req_ready", req_ready, er);
            chk("dp_xin", dp_xin, exp_dpx);
            chk("inflight", inflight, q.size());
            chk("credit_bound", inflight <= FD, 1);
            fn = 0;
            foreach (q[m]) if (q[m].due <= cyc) fn++;
            chk("fifo_overflow", fn <= FD, 1);
            ev = 1'b0;
            if (q.size() > 0) ev = (q[0].due <= cyc);
            chk("rsp_valid", rsp_valid, ev);
            if (ev) begin
                chk("rsp_y", rsp_y, horner(q[0].x));
                chk("rsp_id", rsp_id, q[0].id);
            end
            hs_now  = req_valid & req_ready;
            exp_dpx = '0;
            for (int i = 0; i < N; i++) begin
                if (hs_now[i]) begin
                    t.id  = i;
                    t.x   = req_x[i*DW +: DW];
                    t.due = cyc + PL + 2;
                    q.push_back(t);
                    mptr    = i;
                    exp_dpx = t.x;
                    n_iss++;
                end
            end
            if (rsp_valid && rsp_ready) n_rsp++;
            if (ev && rsp_ready) void'(q.pop_front());
        end
    end

    task automatic drive_inputs(input int vprob, input int rprob);
        for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || hs_now[i]) begin
                req_valid[i] = ($urandom_range(99) < vprob);
                req_x[i*DW +: DW] = DW'($urandom);
            end
        end
        rsp_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic cyc_drive(input int vprob, input int rprob);
        @(posedge clk);
        #1;
        drive_inputs(vprob, rprob);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() > 0 || req_valid != '0) && n < 400) begin
            cyc_drive(0, 100);
            n++;
        end
        @(negedge clk);
        chk("drain_inflight", inflight, 0);
    endtask

    task automatic directed(input int id, input logic [DW-1:0] x,
                            input logic [DW-1:0] y_exp);
        int   n;
        logic hs;
        @(posedge clk);
        #1;
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_x[id*DW +: DW] = x;
        rsp_ready = 1'b1;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 20) begin
            @(negedge clk);
            hs = req_valid[id] & req_ready[id];
            n++;
        end
        chk("dir_handshake", hs, 1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 40);
        chk("dir_latency", n, PL + 2);
        chk("dir_y", rsp_y, y_exp);
        chk("dir_id", rsp_id, id);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi;
        int br;
        int n;
        async = 1'b1;
        repeat (3) @(posedge clk);
        #1 async = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_dp_xin", dp_xin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_inflight", inflight, 0);

        directed(2, 18'h00000, 18'h00082);
        directed(1, 18'h01000, 18'h00FFD);
        drain();

        repeat (30) cyc_drive(100, 100);
        bi = n_iss;
        br = n_rsp;
        repeat (30) cyc_drive(100, 100);
        chk("cont_issue_rate", n_iss - bi, 30);
        chk("cont_rsp_rate", n_rsp - br, 30);
        drain();

        bi = n_iss;
        repeat (40) cyc_drive(100, 0);
        @(negedge clk);
        chk("bp_issues", n_iss - bi, FD);
        chk("bp_inflight", inflight, FD);
        chk("bp_ready", req_ready, 0);
        bi = n_iss;
        cyc_drive(100, 100);
        repeat (10) cyc_drive(100, 0);
        chk("bp_one_more", n_iss - bi, 1);
        drain();

        bi = n_iss;
        br = n_rsp;
        repeat (400) cyc_drive(30, 50);
        drain();
        chk("sparse_count", n_rsp - br, n_iss - bi);

        bi = n_iss;
        n  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (n_iss - bi >= 10 || n >= 100) break;
            drive_inputs(100, 0);
            n++;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_inflight", inflight, 10);
        @(posedge clk);
        #1 async = 1'b1;
        @(posedge clk);
        #1 async = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_dp_xin", dp_xin, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_y", rsp_y, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        chk("mid_rst_inflight", inflight, 0);
        repeat (30) cyc_drive(0, 100);
        chk("no_stale", n_rsp, 0);

        @(posedge clk);
        #1;
        req_valid = 4'b1001;
        req_x[0*DW +: DW] = DW'($urandom);
        req_x[3*DW +: DW] = DW'($urandom);
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rr_restart", req_ready, 4'b0001);
        drain();
        chk("post_rst_rsp", n_rsp, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cheb_eval_sched.md
Name: cheb_eval_sched

Overview:
- Round-robin request scheduler and result router for the fixed-latency pipelined Chebyshev polynomial evaluator (Horner datapath, 18-bit Q6.12, no valid/ready of its own).
- Arbitrates N requesters onto the single datapath input and tracks each in-flight sample with a latency-matched tag pipe.
- Buffers results in a response FIFO and returns them in issue order, tagged with the requester ID.
- Credit-based issue guarantees no result is dropped under response backpressure.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- PIPE_LAT, 12, cycles from sample on dp_xin to its result on dp_yout; must match the datapath build
- FIFO_DEPTH, 16, response FIFO entries; must be >= 1; full throughput requires FIFO_DEPTH >= PIPE_LAT+2
- DW, 18, sample/result width

Ports:
- clk  in  1  clock
- async  in  1  reset, synchronous, active-high; same net drives the datapath reset
- req_valid  in  N_REQ  per-requester sample valid
- req_x  in  N_REQ*DW  per-requester sample; slice i = bits [i*DW +: DW]
- req_ready  out  N_REQ  one-hot or zero grant; handshake on req_valid[i] & req_ready[i]
- dp_xin  out  DW  sample to datapath (registered)
- dp_yout  in  DW  result from datapath
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts
- rsp_y  out  DW  polynomial result
- rsp_id  out  $clog2(N_REQ)  originating requester
- inflight  out  $clog2(PIPE_LAT+FIFO_DEPTH+1)  samples in pipe plus FIFO occupancy

Behaviour:
- Reset (async=1 at posedge): req_ready=0, dp_xin=0, rsp_valid=0, rsp_y=0, rsp_id=0, inflight=0, RR pointer=N_REQ-1, tag pipe cleared, FIFO emptied. Reset mid-operation discards all in-flight and buffered samples; no response is emitted for them.
- Credit: can_issue = (inflight < FIFO_DEPTH). inflight = tag-pipe valid count + FIFO count; it increments on issue, decrements on response pop, and is unchanged on a simultaneous issue and pop.
- Arbitration: combinational. If can_issue, grant the first i with req_valid[i], searching cyclically from ptr+1. req_ready is asserted only for the granted i; req_ready is all-zero when can_issue=0 or no request is valid.
- ptr updates to the granted index on handshake only; it holds when idle. Requesters must hold req_valid/req_x until accepted.
- Issue at edge t: dp_xin <= req_x[grant] (visible cycle t+1); tag pipe stage 0 <= {1, grant}.
- Idle cycle: dp_xin <= 0 and tag stage 0 <= {0, 0}. Bubble results are never written to the FIFO.
- Tag pipe: PIPE_LAT+1 stages of shift register, so the tag aligns with dp_yout in cycle t+1+PIPE_LAT.
- When the aligned tag valid=1, dp_yout and the tag id are written to the FIFO at that edge.
- Credit guarantees the FIFO is never written while full. The bench asserts this.
- FIFO is a first-word-fall-through circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
- rsp_valid = !empty; rsp_y and rsp_id come from the head entry; pop on rsp_valid & rsp_ready.
- Simultaneous push and pop while full is impossible (credit). When empty, a push does not bypass to the output in the same cycle.
- Minimum latency from req handshake to rsp_valid is PIPE_LAT+2 cycles. Results are returned in global issue order. Peak throughput is one sample per cycle.
- Outputs to the consumer are stable while rsp_valid=1 and rsp_ready=0.
- No arithmetic on data; widths pass through unchanged.

Decomposition:
- Package cheb_pkg:
  - DW
  - coefficient localparams COEF0..COEF4 (0x00082, 0x01CC8, 0x3DF43, 0x01EC5, 0x3F4AB)
  - typedef rsp_entry_t {logic [DW-1:0] y; logic [IDW-1:0] id;}
  - default PIPE_LAT
- One sub-module: cheb_rsp_fifo (parameterized sync FWFT FIFO of rsp_entry_t, with count output). The arbiter and tag pipe stay inline.

Test Plan:
- Reset, then single request on req 2 with x=0x00000 -> rsp_valid exactly PIPE_LAT+2 cycles after handshake; rsp_y=0x00082, rsp_id=2.
- req 1 with x=0x01000 (1.0) -> rsp_y=0x00FFD (coefficient sum mod 2^18), rsp_id=1.
- All 4 requesters valid continuously, rsp_ready=1 -> grants cycle 0,1,2,3,0,…; one issue per cycle; responses in issue order with matching ids; no gaps after fill.
- rsp_ready=0 with continuous requests -> exactly FIFO_DEPTH issues, then req_ready=0; inflight=16. Raise rsp_ready for one cycle -> exactly one further issue; no FIFO overflow assertion fires.
- Sparse requests with idle gaps and random rsp_ready -> bubbles never produce responses; response count equals issue count; ids and values match the golden Horner model.
- Assert async for one cycle with 10 samples in flight -> next cycle all outputs at reset values; no stale responses afterwards; new request completes normally with ptr restarting at req 0.
